// File: rtl/reindeer_mem_responder_if.sv
// Word-wide memory request/response bus between an initiator and reindeer_mem_responder.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 15
`endif

interface reindeer_mem_responder_if;
    logic [`MEM_ADDR_BITS-1:0] mem_addr;
    logic [3:0]                mem_write_en;
    logic [31:0]               mem_write_data;
    logic                      mem_read_req;
    logic [31:0]               mem_read_data;
    logic                      mem_ready;
    logic                      mem_busy;

    modport master (
        output mem_addr, mem_write_en, mem_write_data, mem_read_req,
        input  mem_read_data, mem_ready, mem_busy
    );

    modport slave (
        input  mem_addr, mem_write_en, mem_write_data, mem_read_req,
        output mem_read_data, mem_ready, mem_busy
    );
endinterface

// File: rtl/reindeer_mem_responder.sv
// Splits 32-bit word reads/writes into two 16-bit SRAM half-word accesses.
// Optional REINDEER_MEM_HALF_SKIP_EN: skip a write half whose byte enables are all zero.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 15
`endif

module reindeer_mem_responder (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sync_reset,
    reindeer_mem_responder_if.slave mem,
    output logic [`MEM_ADDR_BITS:0] sram_addr,
    output logic                    sram_rd,
    output logic                    sram_wr,
    output logic [1:0]              sram_be,
    output logic [15:0]             sram_wdata,
    input  logic [15:0]             sram_rdata
);

`ifdef REINDEER_MEM_HALF_SKIP_EN
    localparam bit HalfSkip = 1'b1;
`else
    localparam bit HalfSkip = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle, StRdLo, StRdHi, StRdCap, StWrLo, StWrHi, StDone
    } state_e;

    state_e                    state_q;
    logic [`MEM_ADDR_BITS-1:0] addr_q;
    logic [1:0]                hi_be_q;
    logic [15:0]               hi_data_q;
    logic [15:0]               rd_lo_q;

    assign mem.mem_busy = (state_q != StIdle);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= StIdle;
            addr_q            <= '0;
            hi_be_q           <= '0;
            hi_data_q         <= '0;
            rd_lo_q           <= '0;
            mem.mem_read_data <= '0;
            mem.mem_ready     <= 1'b0;
            sram_addr         <= '0;
            sram_rd           <= 1'b0;
            sram_wr           <= 1'b0;
            sram_be           <= '0;
            sram_wdata        <= '0;
        end else if (sync_reset) begin
            state_q           <= StIdle;
            addr_q            <= '0;
            hi_be_q           <= '0;
            hi_data_q         <= '0;
            rd_lo_q           <= '0;
            mem.mem_read_data <= '0;
            mem.mem_ready     <= 1'b0;
            sram_addr         <= '0;
            sram_rd           <= 1'b0;
            sram_wr           <= 1'b0;
            sram_be           <= '0;
            sram_wdata        <= '0;
        end else begin
            mem.mem_ready <= 1'b0;
            sram_rd       <= 1'b0;
            sram_wr       <= 1'b0;
            sram_be       <= '0;
            unique case (state_q)
                StIdle: begin
                    // Write has priority; a simultaneous read is dropped.
                    if (|mem.mem_write_en) begin
                        addr_q    <= mem.mem_addr;
                        hi_be_q   <= mem.mem_write_en[3:2];
                        hi_data_q <= mem.mem_write_data[31:16];
                        sram_wr   <= 1'b1;
                        if (HalfSkip && (mem.mem_write_en[1:0] == 2'b00)) begin
                            state_q    <= StWrHi;
                            sram_addr  <= {mem.mem_addr, 1'b1};
                            sram_be    <= mem.mem_write_en[3:2];
                            sram_wdata <= mem.mem_write_data[31:16];
                        end else begin
                            state_q    <= StWrLo;
                            sram_addr  <= {mem.mem_addr, 1'b0};
                            sram_be    <= mem.mem_write_en[1:0];
                            sram_wdata <= mem.mem_write_data[15:0];
                        end
                    end else if (mem.mem_read_req) begin
                        addr_q    <= mem.mem_addr;
                        state_q   <= StRdLo;
                        sram_rd   <= 1'b1;
                        sram_addr <= {mem.mem_addr, 1'b0};
                    end
                end
                StRdLo: begin
                    state_q   <= StRdHi;
                    sram_rd   <= 1'b1;
                    sram_addr <= {addr_q, 1'b1};
                end
                StRdHi: begin
                    rd_lo_q <= sram_rdata;
                    state_q <= StRdCap;
                end
                StRdCap: begin
                    mem.mem_read_data <= {sram_rdata, rd_lo_q};
                    mem.mem_ready     <= 1'b1;
                    state_q           <= StDone;
                end
                StWrLo: begin
                    if (HalfSkip && (hi_be_q == 2'b00)) begin
                        mem.mem_ready <= 1'b1;
                        state_q       <= StDone;
                    end else begin
                        state_q    <= StWrHi;
                        sram_wr    <= 1'b1;
                        sram_addr  <= {addr_q, 1'b1};
                        sram_be    <= hi_be_q;
                        sram_wdata <= hi_data_q;
                    end
                end
                StWrHi: begin
                    mem.mem_ready <= 1'b1;
                    state_q       <= StDone;
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_reindeer_mem_responder.sv
// Directed self-checking bench for reindeer_mem_responder with a behavioural half-word SRAM.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 15
`endif

module tb_reindeer_mem_responder;
    localparam int AW = `MEM_ADDR_BITS;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          sync_reset;
    logic [AW:0]   sram_addr;
    logic          sram_rd;
    logic          sram_wr;
    logic [1:0]    sram_be;
    logic [15:0]   sram_wdata;
    logic [15:0]   sram_rdata;

    logic [15:0]   sram_mem [0:(1 << (AW + 1)) - 1];

    int n_checks = 0;
    int n_errors = 0;
    int ready_cnt = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int overlap_cnt = 0;

    reindeer_mem_responder_if mem_bus ();

    reindeer_mem_responder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sync_reset (sync_reset),
        .mem        (mem_bus),
        .sram_addr  (sram_addr),
        .sram_rd    (sram_rd),
        .sram_wr    (sram_wr),
        .sram_be    (sram_be),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    // Read data appears one cycle after the strobe, as a synchronous SRAM would return it.
    always @(posedge clk) begin
        if (sram_rd) sram_rdata <= sram_mem[sram_addr];
        if (sram_wr) begin
            if (sram_be[0]) sram_mem[sram_addr][7:0]  <= sram_wdata[7:0];
            if (sram_be[1]) sram_mem[sram_addr][15:8] <= sram_wdata[15:8];
        end
    end

    always @(negedge clk) begin
        if (mem_bus.mem_ready) ready_cnt++;
        if (sram_rd) rd_cnt++;
        if (sram_wr) wr_cnt++;
        if (sram_rd && sram_wr) overlap_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [AW:0] ha(input int a, input bit h);
        logic [31:0] av;
        av = a;
        return {av[AW-1:0], h};
    endfunction

    // Drive a request for one accept edge; returns at the first sampling point after it.
    task automatic issue(input int a, input logic [3:0] we, input logic [31:0] data,
                         input logic rd);
        mem_bus.mem_addr       = AW'(a);
        mem_bus.mem_write_en   = we;
        mem_bus.mem_write_data = data;
        mem_bus.mem_read_req   = rd;
        tick();
        mem_bus.mem_write_en   = 4'h0;
        mem_bus.mem_read_req   = 1'b0;
    endtask

    task automatic clear_counts();
        ready_cnt   = 0;
        rd_cnt      = 0;
        wr_cnt      = 0;
        overlap_cnt = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_rd"},    32'(sram_rd), 32'h0);
        check_val({tag, "_wr"},    32'(sram_wr), 32'h0);
        check_val({tag, "_addr"},  32'(sram_addr), 32'h0);
        check_val({tag, "_be"},    32'(sram_be), 32'h0);
        check_val({tag, "_wdata"}, 32'(sram_wdata), 32'h0);
        check_val({tag, "_ready"}, 32'(mem_bus.mem_ready), 32'h0);
        check_val({tag, "_busy"},  32'(mem_bus.mem_busy), 32'h0);
        check_val({tag, "_rdata"}, mem_bus.mem_read_data, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < (1 << (AW + 1)); i++) sram_mem[i] = 16'h0000;
        sram_mem[ha(5, 1'b0)] = 16'h1234;
        sram_mem[ha(5, 1'b1)] = 16'hABCD;
        sram_mem[ha(9, 1'b0)] = 16'h6666;
        sram_mem[ha(9, 1'b1)] = 16'h7777;
        sram_rdata             = 16'h0000;
        reset_n                = 1'b0;
        sync_reset             = 1'b0;
        mem_bus.mem_addr       = '0;
        mem_bus.mem_write_en   = 4'h0;
        mem_bus.mem_write_data = 32'h0;
        mem_bus.mem_read_req   = 1'b0;
        @(negedge clk);
        tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        ticks(2);

        // Read word 5: strobes at T1/T2, ready with assembled word at T4.
        clear_counts();
        issue(5, 4'h0, 32'h0, 1'b1);
        check_val("rd_t1_rd",   32'(sram_rd), 32'h1);
        check_val("rd_t1_addr", 32'(sram_addr), 32'(ha(5, 1'b0)));
        check_val("rd_t1_busy", 32'(mem_bus.mem_busy), 32'h1);
        tick();
        check_val("rd_t2_rd",   32'(sram_rd), 32'h1);
        check_val("rd_t2_addr", 32'(sram_addr), 32'(ha(5, 1'b1)));
        tick();
        check_val("rd_t3_rd",    32'(sram_rd), 32'h0);
        check_val("rd_t3_ready", 32'(mem_bus.mem_ready), 32'h0);
        tick();
        check_val("rd_t4_ready", 32'(mem_bus.mem_ready), 32'h1);
        check_val("rd_t4_data",  mem_bus.mem_read_data, 32'hABCD1234);
        tick();
        check_val("rd_t5_ready", 32'(mem_bus.mem_ready), 32'h0);
        check_val("rd_t5_busy",  32'(mem_bus.mem_busy), 32'h0);
        check_val("rd_pulses",   32'(ready_cnt), 32'd1);

        // Full write to word 7.
        clear_counts();
        issue(7, 4'hF, 32'hDEADBEEF, 1'b0);
        check_val("wr_t1_wr",    32'(sram_wr), 32'h1);
        check_val("wr_t1_addr",  32'(sram_addr), 32'(ha(7, 1'b0)));
        check_val("wr_t1_be",    32'(sram_be), 32'h3);
        check_val("wr_t1_wdata", 32'(sram_wdata), 32'hBEEF);
        tick();
        check_val("wr_t2_wr",    32'(sram_wr), 32'h1);
        check_val("wr_t2_addr",  32'(sram_addr), 32'(ha(7, 1'b1)));
        check_val("wr_t2_be",    32'(sram_be), 32'h3);
        check_val("wr_t2_wdata", 32'(sram_wdata), 32'hDEAD);
        tick();
        check_val("wr_t3_ready", 32'(mem_bus.mem_ready), 32'h1);
        check_val("wr_t3_wr",    32'(sram_wr), 32'h0);
        check_val("wr_keep_rd",  mem_bus.mem_read_data, 32'hABCD1234);
        ticks(2);
        check_val("wr_mem_lo",   32'(sram_mem[ha(7, 1'b0)]), 32'hBEEF);
        check_val("wr_mem_hi",   32'(sram_mem[ha(7, 1'b1)]), 32'hDEAD);
        check_val("wr_pulses",   32'(ready_cnt), 32'd1);

        // Single-byte write into the upper half of word 9.
        clear_counts();
        issue(9, 4'b0100, 32'h00550000, 1'b0);
`ifdef REINDEER_MEM_HALF_SKIP_EN
        check_val("bw_t1_wr",    32'(sram_wr), 32'h1);
        check_val("bw_t1_addr",  32'(sram_addr), 32'(ha(9, 1'b1)));
        check_val("bw_t1_be",    32'(sram_be), 32'h1);
        check_val("bw_t1_wdata", 32'(sram_wdata), 32'h0055);
        tick();
        check_val("bw_t2_ready", 32'(mem_bus.mem_ready), 32'h1);
`else
        check_val("bw_t1_wr",    32'(sram_wr), 32'h1);
        check_val("bw_t1_addr",  32'(sram_addr), 32'(ha(9, 1'b0)));
        check_val("bw_t1_be",    32'(sram_be), 32'h0);
        tick();
        check_val("bw_t2_addr",  32'(sram_addr), 32'(ha(9, 1'b1)));
        check_val("bw_t2_be",    32'(sram_be), 32'h1);
        check_val("bw_t2_wdata", 32'(sram_wdata), 32'h0055);
        check_val("bw_t2_ready", 32'(mem_bus.mem_ready), 32'h0);
        tick();
        check_val("bw_t3_ready", 32'(mem_bus.mem_ready), 32'h1);
`endif
        ticks(2);
        check_val("bw_mem_lo", 32'(sram_mem[ha(9, 1'b0)]), 32'h6666);
        check_val("bw_mem_hi", 32'(sram_mem[ha(9, 1'b1)]), 32'h7755);
        check_val("bw_pulses", 32'(ready_cnt), 32'd1);

        // Read and write in the same accept cycle: write wins.
        clear_counts();
        issue(3, 4'hF, 32'h11223344, 1'b1);
        ticks(5);
        check_val("col_pulses",  32'(ready_cnt), 32'd1);
        check_val("col_no_rd",   32'(rd_cnt), 32'd0);
        check_val("col_mem_lo",  32'(sram_mem[ha(3, 1'b0)]), 32'h3344);
        check_val("col_mem_hi",  32'(sram_mem[ha(3, 1'b1)]), 32'h1122);
        check_val("col_keep_rd", mem_bus.mem_read_data, 32'hABCD1234);

        // A write presented while a read is in flight is ignored.
        clear_counts();
        issue(5, 4'h0, 32'h0, 1'b1);
        mem_bus.mem_addr       = AW'(11);
        mem_bus.mem_write_en   = 4'hF;
        mem_bus.mem_write_data = 32'hCAFEF00D;
        ticks(2);
        mem_bus.mem_write_en   = 4'h0;
        ticks(4);
        check_val("busy_no_wr",   32'(wr_cnt), 32'd0);
        check_val("busy_pulses",  32'(ready_cnt), 32'd1);
        check_val("busy_mem",     32'(sram_mem[ha(11, 1'b0)]), 32'h0000);
        check_val("busy_rd_data", mem_bus.mem_read_data, 32'hABCD1234);
        check_val("no_overlap",   32'(overlap_cnt), 32'd0);

        // Synchronous abort during the high half of a write.
        clear_counts();
        issue(13, 4'hF, 32'h55AA33CC, 1'b0);
        tick();
        check_val("sr_wrhi_addr", 32'(sram_addr), 32'(ha(13, 1'b1)));
        sync_reset = 1'b1;
        tick();
        check_all_zero("sync_rst");
        sync_reset = 1'b0;
        ticks(3);
        check_val("sr_no_ready", 32'(ready_cnt), 32'd0);

        // Asynchronous reset in the middle of RD_HI.
        clear_counts();
        issue(5, 4'h0, 32'h0, 1'b1);
        tick();
        check_val("ar_rdhi_addr", 32'(sram_addr), 32'(ha(5, 1'b1)));
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        ticks(4);
        check_val("ar_no_ready", 32'(ready_cnt), 32'd0);
        check_val("ar_idle",     32'(mem_bus.mem_busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reindeer_mem_responder.md
REINDEER_MEM_RESPONDER -- requirements
Module: reindeer_mem_responder

Interface
REQ-001 Parameters SHALL be: none (widths from `MEM_ADDR_BITS`, `XLEN`=32, `XLEN_BYTES`=4 in common.vh).
REQ-002 clk  input  1  system clock, all logic rising-edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 sync_reset  input  1  synchronous abort, active-high.
REQ-005 mem_addr  input  MEM_ADDR_BITS  32-bit word address from the memory initiator.
REQ-006 mem_write_en  input  4  byte-lane write enables; bit n covers mem_write_data[8n+7:8n].
REQ-007 mem_write_data  input  32  write word.
REQ-008 mem_read_req  input  1  read request.
REQ-009 mem_read_data  output  32  registered read word.
REQ-010 mem_ready  output  1  one-cycle completion pulse (read or write).
REQ-011 mem_busy  output  1  high whenever state is not IDLE.
REQ-012 sram_addr  output  MEM_ADDR_BITS+1  16-bit half-word address, {word_addr, half}, half=0 low, 1 high.
REQ-013 sram_rd / sram_wr  output  1 each  half-word read / write strobe.
REQ-014 sram_be  output  2  byte enables for the current half-word write.
REQ-015 sram_wdata  output  16  half-word write data.
REQ-016 sram_rdata  input  16  read data, valid exactly one cycle after sram_rd with matching sram_addr.

Function
REQ-017 States SHALL be IDLE, RD_LO, RD_HI, RD_CAP, WR_LO, WR_HI, DONE; all SRAM outputs and mem_ready SHALL be registered.
REQ-018 In IDLE a request SHALL be accepted when |mem_write_en or mem_read_req; addr, enables and data latched at the accept edge.
REQ-019 Simultaneous write and read in IDLE: write SHALL win, read SHALL be dropped, one mem_ready pulse only.
REQ-020 Requests while mem_busy SHALL be ignored; initiator holds or re-issues after mem_ready.
REQ-021 Read: RD_LO drives sram_rd=1, sram_addr={a,0}; RD_HI drives {a,1} and captures sram_rdata into low half; RD_CAP captures high half; DONE asserts mem_ready=1 with new mem_read_data.
REQ-022 Read latency: mem_ready SHALL assert 4 cycles after the accept edge (accept cycle T0, ready T4).
REQ-023 Write: WR_LO drives sram_wr=1, sram_be=we[1:0], sram_wdata=data[15:0], addr {a,0}; WR_HI drives we[3:2], data[31:16], {a,1}; DONE pulses mem_ready (ready at T3).
REQ-024 sram_rd and sram_wr SHALL never be high in the same cycle; both low in IDLE, RD_CAP, DONE.
REQ-025 DONE SHALL always return to IDLE next cycle; a request present during DONE SHALL be ignored (min 1 idle cycle between transactions).
REQ-026 mem_read_data SHALL hold its value across writes and until the next read's DONE.
REQ-027 sram_addr wraps naturally at MEM_ADDR_BITS+1 bits; no range check.

Reset
REQ-028 reset_n low SHALL force state IDLE, mem_read_data=0, mem_ready=0, sram_rd=0, sram_wr=0, sram_be=0, sram_wdata=0, sram_addr=0, asynchronously.
REQ-029 sync_reset high SHALL apply the same values at the next edge, aborting any transaction with no mem_ready pulse; an in-progress write MAY have completed its low half.

Configuration
REQ-030 Macro REINDEER_MEM_HALF_SKIP_EN: when defined, a write with we[1:0]==0 SHALL skip WR_LO and a write with we[3:2]==0 SHALL skip WR_HI (single-half write ready at T2); when undefined, both halves SHALL always be issued, a zero-enable half with sram_wr=1 and sram_be=0.
REQ-031 Reads SHALL never be shortened by the macro.

Verification
REQ-032 Reset: reset_n low mid-RD_HI -> all outputs 0 immediately, state IDLE, no mem_ready.
REQ-033 Read: sram holds 0x1234 @ {5,0}, 0xABCD @ {5,1}; mem_read_req, mem_addr=5 at T0 -> mem_ready at T4, mem_read_data=0xABCD1234.
REQ-034 Full write: mem_write_en=4'hF, addr=7, data=0xDEADBEEF -> T1 sram {7,0} be=11 0xBEEF, T2 {7,1} be=11 0xDEAD, mem_ready at T3.
REQ-035 Byte write we=4'b0100, data=0x00550000: macro defined -> only {a,1} be=01 0x0055, ready T2; undefined -> {a,0} be=00 then {a,1}, ready T3.
REQ-036 Collision: read+write same cycle -> write performed, single mem_ready, mem_read_data unchanged; request during busy -> ignored.
REQ-037 sync_reset during WR_HI -> next edge IDLE, outputs 0, no mem_ready.
